// File: rtl/ap_ctrl_drv_pkg.sv
// Shared types and default sizing for the ap_ctrl_hs transaction driver.
package ap_ctrl_drv_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_MAX_OUT = 8;
    localparam int DEF_CYC_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

endpackage

// File: rtl/ap_ctrl_ts_fifo.sv
// In-order accept-timestamp FIFO; an empty FIFO with push+pop bypasses din.
module ap_ctrl_ts_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          bypass;
    logic          do_wr;
    logic          do_rd;

    assign empty  = (count == '0);
    assign bypass = empty & push & pop;
    assign do_wr  = push & ~bypass;
    assign do_rd  = pop & ~empty;
    assign head   = empty ? din : mem[rd_ptr];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= nxt(wr_ptr);
            if (do_rd) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/ap_ctrl_driver.sv
// Issues trans_num ap_ctrl_hs starts per run with bounded outstanding work.
// Define AP_CTRL_LATENCY_EN to add accept-to-done latency min/max tracking.
module ap_ctrl_driver
    import ap_ctrl_drv_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_OUT = DEF_MAX_OUT,
    parameter int CYC_W   = DEF_CYC_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         run,
    input  logic [CNT_W-1:0]             trans_num,
    output logic                         ap_start,
    input  logic                         ap_ready,
    input  logic                         ap_done,
    input  logic                         ap_idle,
    output logic                         busy,
    output logic                         finish,
    output logic                         err,
    output logic [CNT_W-1:0]             issued_cnt,
    output logic [CNT_W-1:0]             done_cnt,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic [CYC_W-1:0]             cycle_cnt
`ifdef AP_CTRL_LATENCY_EN
    ,
    output logic [CYC_W-1:0]             lat_min,
    output logic [CYC_W-1:0]             lat_max
`endif
);

    localparam int OW = $clog2(MAX_OUT + 1);

    state_t           state;
    logic [CNT_W-1:0] target;
    logic             accept;
    logic             done_ok;
    logic             spurious;

    assign ap_start = (state == ISSUE) && (outstanding < OW'(MAX_OUT));
    assign accept   = ap_start & ap_ready;
    // A done racing the very first accept is still a real completion.
    assign done_ok  = ap_done & ((outstanding != '0) | accept);
    assign spurious = ap_done & ~done_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            finish      <= 1'b0;
            err         <= 1'b0;
            target      <= '0;
            issued_cnt  <= '0;
            done_cnt    <= '0;
            outstanding <= '0;
            cycle_cnt   <= '0;
        end else begin
            if (spurious) err <= 1'b1;
            if (accept) issued_cnt <= issued_cnt + CNT_W'(1);
            if (done_ok) done_cnt <= done_cnt + CNT_W'(1);
            unique case ({accept, done_ok})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: ;
            endcase
            if (busy && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + CYC_W'(1);

            unique case (state)
                IDLE: begin
                    if (run) begin
                        target     <= trans_num;
                        issued_cnt <= '0;
                        done_cnt   <= '0;
                        cycle_cnt  <= '0;
                        busy       <= 1'b1;
                        if (trans_num == '0) begin
                            state  <= FIN;
                            finish <= 1'b1;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (accept && (issued_cnt + CNT_W'(1) == target))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if ((outstanding == '0) && ap_idle) begin
                        state  <= FIN;
                        finish <= 1'b1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    finish <= 1'b0;
                    busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AP_CTRL_LATENCY_EN
    logic [CYC_W-1:0] head;
    logic [CYC_W-1:0] lat;

    ap_ctrl_ts_fifo #(
        .DEPTH (MAX_OUT),
        .W     (CYC_W)
    ) u_ts_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .din   (cycle_cnt),
        .pop   (done_ok),
        .head  (head)
    );

    assign lat = cycle_cnt - head;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_min <= '0;
            lat_max <= '0;
        end else if ((state == IDLE) && run) begin
            lat_min <= '1;
            lat_max <= '0;
        end else if (done_ok) begin
            if (lat < lat_min) lat_min <= lat;
            if (lat > lat_max) lat_max <= lat;
        end
    end
`endif

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Self-checking bench: transaction-level reference model plus directed cases.
module tb_ap_ctrl_driver;

    localparam int CNT_W   = 16;
    localparam int MAX_OUT = 8;
    localparam int CYC_W   = 32;
    localparam int OW      = $clog2(MAX_OUT + 1);
    localparam longint CYC_MAX = (64'd1 << CYC_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic             run = 1'b0;
    logic [CNT_W-1:0] trans_num = '0;
    logic             ap_ready = 1'b0;
    logic             ap_done = 1'b0;
    logic             ap_idle = 1'b1;
    logic             ap_start, busy, finish, err;
    logic [CNT_W-1:0] issued_cnt, done_cnt;
    logic [OW-1:0]    outstanding;
    logic [CYC_W-1:0] cycle_cnt;
`ifdef AP_CTRL_LATENCY_EN
    logic [CYC_W-1:0] lat_min, lat_max;
`endif

    logic       run2 = 1'b0;
    logic [7:0] trans2 = '0;
    logic       ready2 = 1'b0;
    logic       done2 = 1'b0;
    logic       idle2 = 1'b1;
    logic       start2, busy2, fin2, err2;
    logic [7:0] iss2, dn2;
    logic [1:0] out2;
    logic [3:0] cyc2;
`ifdef AP_CTRL_LATENCY_EN
    logic [3:0] lmin2, lmax2;
`endif

    ap_ctrl_driver #(.CNT_W(CNT_W), .MAX_OUT(MAX_OUT), .CYC_W(CYC_W)) u_dut (
        .clock(clock), .reset(reset), .run(run), .trans_num(trans_num),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_idle(ap_idle), .busy(busy), .finish(finish), .err(err),
        .issued_cnt(issued_cnt), .done_cnt(done_cnt),
        .outstanding(outstanding), .cycle_cnt(cycle_cnt)
`ifdef AP_CTRL_LATENCY_EN
        , .lat_min(lat_min), .lat_max(lat_max)
`endif
    );

    ap_ctrl_driver #(.CNT_W(8), .MAX_OUT(2), .CYC_W(4)) u_dut2 (
        .clock(clock), .reset(reset), .run(run2), .trans_num(trans2),
        .ap_start(start2), .ap_ready(ready2), .ap_done(done2),
        .ap_idle(idle2), .busy(busy2), .finish(fin2), .err(err2),
        .issued_cnt(iss2), .done_cnt(dn2),
        .outstanding(out2), .cycle_cnt(cyc2)
`ifdef AP_CTRL_LATENCY_EN
        , .lat_min(lmin2), .lat_max(lmax2)
`endif
    );

    int checks = 0;
    int errors = 0;

    // reference model: run bookkeeping plus a queue of accept timestamps
    bit     m_act, m_drain, m_fin, m_err;
    int     m_target, m_issued, m_done;
    longint m_cyc, m_lmin, m_lmax;
    longint ts_q[$];

    // kernel emulation and observation logs
    int now = 0;
    int due_q[$];
    int lat_q[$];
    int fix_lat = 5;
    bit force_done = 1'b0;
    bit rnd_ready = 1'b0, rnd_idle = 1'b0, rnd_run = 1'b0;
    int dut_acc[$];
    int busy_seen, fin_seen, fin_at, run_at, s2;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_lat();
        if (lat_q.size() > 0) return lat_q.pop_front();
        if (fix_lat > 0) return fix_lat;
        return $urandom_range(1, 10);
    endfunction

    task automatic model_reset();
        m_act = 0; m_drain = 0; m_fin = 0; m_err = 0;
        m_target = 0; m_issued = 0; m_done = 0;
        m_cyc = 0; m_lmin = 0; m_lmax = 0;
        ts_q.delete();
        due_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, ap_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finish"}, finish, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_issued"}, issued_cnt, 0);
        chk({tag, "_done"}, done_cnt, 0);
        chk({tag, "_outst"}, outstanding, 0);
        chk({tag, "_cycle"}, cycle_cnt, 0);
`ifdef AP_CTRL_LATENCY_EN
        chk({tag, "_lat_min"}, lat_min, 0);
        chk({tag, "_lat_max"}, lat_max, 0);
`endif
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk_zero(tag);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic cycle();
        logic   exp_start, acc, dok;
        int     k, old_n;
        bit     old_act;
        longint l;
        if (rnd_ready) ap_ready = ($urandom_range(0, 9) < 7);
        if (rnd_run && m_act) begin
            run = !m_fin && ($urandom_range(0, 5) == 0);
            trans_num = CNT_W'($urandom_range(0, 9));
        end
        k = -1;
        foreach (due_q[i]) if (k < 0 && due_q[i] <= now) k = i;
        ap_done = force_done;
        if (k >= 0) begin
            ap_done = 1'b1;
            due_q.delete(k);
        end
        ap_idle = (due_q.size() == 0) && (!rnd_idle || $urandom_range(0, 3) != 0);

        exp_start = m_act && !m_fin && !m_drain && (ts_q.size() < MAX_OUT);
        chk("ap_start", ap_start, exp_start);
        chk("busy", busy, m_act);
        chk("finish", finish, m_fin);
        chk("err", err, m_err);
        chk("issued_cnt", issued_cnt, m_issued);
        chk("done_cnt", done_cnt, m_done);
        chk("outstanding", outstanding, ts_q.size());
        chk("cycle_cnt", cycle_cnt, m_cyc);
`ifdef AP_CTRL_LATENCY_EN
        chk("lat_min", lat_min, m_lmin);
        chk("lat_max", lat_max, m_lmax);
`endif
        if (ap_start === 1'b1 && ap_ready) dut_acc.push_back(now);
        if (busy === 1'b1) busy_seen++;
        if (finish === 1'b1) begin
            fin_seen++;
            fin_at = now;
        end

        acc = exp_start && ap_ready;
        if (acc) due_q.push_back(now + next_lat());
        dok = ap_done && (ts_q.size() > 0 || acc);
        old_n = ts_q.size();
        old_act = m_act;
        @(posedge clock);

        if (ap_done && !dok) m_err = 1;
        if (acc) begin
            m_issued++;
            ts_q.push_back(m_cyc);
        end
        if (dok) begin
            l = m_cyc - ts_q.pop_front();
            m_done++;
            if (l < m_lmin) m_lmin = l;
            if (l > m_lmax) m_lmax = l;
        end
        if (old_act && m_cyc < CYC_MAX) m_cyc++;
        if (m_fin) begin
            m_fin = 0;
            m_act = 0;
        end else if (!m_act) begin
            if (run) begin
                m_target = int'(trans_num);
                m_issued = 0; m_done = 0; m_cyc = 0;
                m_lmin = CYC_MAX; m_lmax = 0;
                m_act = 1;
                m_fin = (trans_num == 0);
            end
        end else if (m_drain) begin
            if (old_n == 0 && ap_idle) begin
                m_drain = 0;
                m_fin = 1;
            end
        end else if (acc && m_issued == m_target) begin
            m_drain = 1;
        end
        now++;
        @(negedge clock);
    endtask

    task automatic run_go(input int n);
        run = 1'b1;
        trans_num = CNT_W'(n);
        run_at = now;
        cycle();
        run = 1'b0;
    endtask

    task automatic wait_fin(input int budget);
        for (int i = 0; i < budget && m_act; i++) cycle();
        chk("run_timeout", busy, 1'b0);
    endtask

    task automatic clr_logs();
        dut_acc.delete();
        busy_seen = 0;
        fin_seen = 0;
        fin_at = -1;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset("reset");
        cycle();

        // four back-to-back issues, done 5 cycles after each accept
        clr_logs();
        ap_ready = 1'b1;
        fix_lat = 5;
        run_go(4);
        wait_fin(100);
        chk("b2b_accepts", dut_acc.size(), 4);
        if (dut_acc.size() == 4) chk("b2b_consec", dut_acc[3] - dut_acc[0], 3);
        chk("b2b_done_cnt", done_cnt, 4);
        chk("b2b_finish", fin_seen, 1);
        chk("b2b_err", err, 0);

        // empty run
        clr_logs();
        run_go(0);
        repeat (3) cycle();
        chk("zero_busy", busy_seen, 1);
        chk("zero_fin_at", fin_at, run_at + 1);
        chk("zero_accepts", dut_acc.size(), 0);

        // ready withheld while start is up
        clr_logs();
        ap_ready = 1'b0;
        run_go(1);
        repeat (3) begin
            cycle();
            chk("hold_start", ap_start, 1);
        end
        ap_ready = 1'b1;
        wait_fin(100);
        chk("hold_accepts", dut_acc.size(), 1);

        // outstanding limit of 2, done withheld, narrow cycle counter
        ready2 = 1'b1;
        trans2 = 8'd4;
        run2 = 1'b1;
        cycle();
        run2 = 1'b0;
        repeat (2) cycle();
        chk("lim_start_low", start2, 0);
        chk("lim_outst", out2, 2);
        chk("lim_issued", iss2, 2);
        s2 = 0;
        repeat (20) begin
            cycle();
            if (start2 !== 1'b0) s2++;
        end
        chk("lim_start_stay_low", s2, 0);
        chk("lim_cycle_sat", cyc2, 15);
        done2 = 1'b1;
        cycle();
        done2 = 1'b0;
        chk("lim_resume", start2, 1);
        chk("lim_outst_dec", out2, 1);
        cycle();
        chk("lim_issued_3", iss2, 3);
        chk("lim_done_cnt", dn2, 1);
        chk("lim_busy", busy2, 1);
        chk("lim_err", err2, 0);
        chk("lim_fin", fin2, 0);
`ifdef AP_CTRL_LATENCY_EN
        chk("lim_lat_min", lmin2, 15);
        chk("lim_lat_max", lmax2, 15);
`endif

        // randomized runs against the model
        rnd_ready = 1'b1;
        rnd_idle = 1'b1;
        rnd_run = 1'b1;
        fix_lat = 0;
        for (int r = 0; r < 6; r++) begin
            run_go($urandom_range(1, 12));
            wait_fin(600);
        end
        rnd_ready = 1'b0;
        rnd_idle = 1'b0;
        rnd_run = 1'b0;
        run = 1'b0;
        ap_ready = 1'b1;
        repeat (2) cycle();

        // spurious done in idle
        do_reset("reset2");
        ap_ready = 1'b0;
        run_go(1);
        ap_ready = 1'b1;
        fix_lat = 2;
        wait_fin(50);
        force_done = 1'b1;
        cycle();
        force_done = 1'b0;
        chk("spur_err", err, 1);
        chk("spur_done_cnt", done_cnt, 1);
        fix_lat = 3;
        run_go(2);
        wait_fin(100);
        chk("spur_err_sticky", err, 1);
        do_reset("spur_clear");

        // latency 5, 7, 6 with spaced accepts
        lat_q = '{5, 7, 6};
        ap_ready = 1'b0;
        run_go(3);
        repeat (3) begin
            ap_ready = 1'b1;
            cycle();
            ap_ready = 1'b0;
            cycle();
            cycle();
        end
        wait_fin(100);
`ifdef AP_CTRL_LATENCY_EN
        chk("lat_min_5", lat_min, 5);
        chk("lat_max_7", lat_max, 7);
`endif
        chk("lat_done_cnt", done_cnt, 3);

        // reset in the middle of a run
        ap_ready = 1'b1;
        fix_lat = 4;
        run_go(6);
        repeat (3) cycle();
        do_reset("midrun");
        clr_logs();
        repeat (10) cycle();
        chk("midrun_no_finish", fin_seen, 0);
        chk("midrun_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
